// File: rtl/global_pool_stream_pkg.sv
// Shared types and helpers for the global pooling stage.
package global_pool_stream_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } mode_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < 64'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/global_pool_stream_pool_lane.sv
// One channel of the pooling datapath: running max/sum, reciprocal scaling,
// round-half-up and saturation into the registered result.
module global_pool_stream_pool_lane
    import global_pool_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_W      = 38,
    parameter int unsigned RECIP_FRAC = 16,
    parameter int unsigned RECIP      = 1337
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         load,
    input  logic                         accum,
    input  logic                         clear,
    input  logic                         fin,
    input  mode_t                        mode,
    output logic [DATA_WIDTH-1:0]        result
);

    localparam int unsigned PROD_W = ACC_W + RECIP_FRAC + 1;
    localparam logic signed [PROD_W-1:0] RCP    = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] RND    = PROD_W'(1) << (RECIP_FRAC - 1);
    localparam logic signed [PROD_W-1:0] SAT_HI =
        {{(PROD_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_LO =
        {{(PROD_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic [DATA_WIDTH-1:0]    avg_c;

    assign ext = ACC_W'(sample);

    // Max keeps the sign-extended sample so one compare works at full width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= ext;
        end else if (accum) begin
            if (mode == MODE_MAX) begin
                if (ext > acc) begin
                    acc <= ext;
                end
            end else begin
                acc <= acc + ext;
            end
        end
    end

    always_comb begin
        prod   = PROD_W'(acc) * RCP;
        scaled = (prod + RND) >>> RECIP_FRAC;
        if (scaled > SAT_HI) begin
            avg_c = SAT_HI[DATA_WIDTH-1:0];
        end else if (scaled < SAT_LO) begin
            avg_c = SAT_LO[DATA_WIDTH-1:0];
        end else begin
            avg_c = scaled[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else if (fin) begin
            result <= (mode == MODE_MAX) ? acc[DATA_WIDTH-1:0] : avg_c;
        end
    end

endmodule

// File: rtl/global_pool_stream.sv
// Global spatial max/average pooling over a WIDTH x WIDTH raster of CH-channel
// beats; one pooled vector per frame, ready/valid on both sides.
module global_pool_stream
    import global_pool_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CH         = 32,
    parameter int unsigned WIDTH      = 7,
    parameter int unsigned RECIP_FRAC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH*CH-1:0]   i_data,
    input  logic                       valid_in,
    output logic                       in_ready,
    input  logic                       i_mode,
    output logic [DATA_WIDTH*CH-1:0]   o_data,
    output logic                       valid_out,
    input  logic                       out_ready
);

    localparam int unsigned DIM     = WIDTH * WIDTH;
    localparam int unsigned LOG_DIM = clog2(DIM);
    localparam int unsigned CNT_W   = (LOG_DIM > 0) ? LOG_DIM : 1;
    localparam int unsigned ACC_W   = DATA_WIDTH + LOG_DIM;
    localparam int unsigned RECIP   = ((32'd1 << RECIP_FRAC) + DIM / 2) / DIM;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    mode_t             mode_q;
    mode_t             lane_mode;
    logic              beat;
    logic              first;
    logic              last;
    logic              clear;
    logic              fin;
    logic              in_ready_d;
    logic              valid_out_d;

    assign beat  = valid_in & in_ready;
    assign first = beat && (count == '0);
    assign last  = beat && (count == CNT_W'(DIM - 1));
    assign clear = (state == ST_HOLD) && out_ready;
    assign fin   = (state == ST_FINAL);

    // Mode applies from the first beat of a frame; later beats use the latched copy.
    always_comb begin
        lane_mode = mode_q;
        if (first) begin
            lane_mode = mode_t'(i_mode);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_ACCUM: if (last) next_state = ST_FINAL;
            ST_FINAL: next_state = ST_HOLD;
            ST_HOLD:  if (out_ready) next_state = ST_ACCUM;
            default:  next_state = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready_d  = (next_state == ST_ACCUM);
        valid_out_d = (next_state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            valid_out <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            valid_out <= valid_out_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            mode_q <= MODE_MAX;
        end else begin
            if (last) begin
                count <= '0;
            end else if (beat) begin
                count <= count + CNT_W'(1);
            end
            if (first) begin
                mode_q <= mode_t'(i_mode);
            end
        end
    end

    for (genvar c = 0; c < int'(CH); c++) begin : g_lane
        global_pool_stream_pool_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_W      (ACC_W),
            .RECIP_FRAC (RECIP_FRAC),
            .RECIP      (RECIP)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .sample (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .load   (first),
            .accum  (beat && !first),
            .clear  (clear),
            .fin    (fin),
            .mode   (lane_mode),
            .result (o_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_global_pool_stream.sv
// Scoreboard bench for global_pool_stream: a 7x7x32 instance and a 2x2x4 instance.
module tb_global_pool_stream;

    localparam int DW  = 32;
    localparam int CH  = 32;
    localparam int CHB = 4;

    typedef logic [DW*CH-1:0]  vec_a_t;
    typedef logic [DW*CHB-1:0] vec_b_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    vec_a_t a_data = '0;
    logic   a_valid = 1'b0, a_ready, a_mode = 1'b0, a_vout, a_oready = 1'b1;
    vec_a_t a_odata;
    vec_b_t b_data = '0;
    logic   b_valid = 1'b0, b_ready, b_mode = 1'b0, b_vout, b_oready = 1'b1;
    vec_b_t b_odata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    vec_a_t exp_a[$];
    vec_b_t exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    global_pool_stream #(.DATA_WIDTH(32), .CH(32), .WIDTH(7), .RECIP_FRAC(16)) dut_a (
        .clk(clk), .rst(rst), .i_data(a_data), .valid_in(a_valid), .in_ready(a_ready),
        .i_mode(a_mode), .o_data(a_odata), .valid_out(a_vout), .out_ready(a_oready)
    );

    global_pool_stream #(.DATA_WIDTH(32), .CH(4), .WIDTH(2), .RECIP_FRAC(16)) dut_b (
        .clk(clk), .rst(rst), .i_data(b_data), .valid_in(b_valid), .in_ready(b_ready),
        .i_mode(b_mode), .o_data(b_odata), .valid_out(b_vout), .out_ready(b_oready)
    );

    // Monitors: a result is consumed at the next rising edge when valid & ready.
    always @(negedge clk) begin : mon_a
        vec_a_t e;
        int bad;
        if (rst && a_vout && a_oready) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_result got ch0=%0d", $signed(a_odata[DW-1:0]));
            end else begin
                e = exp_a.pop_front();
                bad = -1;
                for (int c = 0; c < CH; c++)
                    if (a_odata[c*DW +: DW] !== e[c*DW +: DW] && bad < 0) bad = c;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL a_result ch%0d got %0d exp %0d", bad,
                             $signed(a_odata[bad*DW +: DW]), $signed(e[bad*DW +: DW]));
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        vec_b_t e;
        int bad;
        if (rst && b_vout && b_oready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_result got ch0=%0d", $signed(b_odata[DW-1:0]));
            end else begin
                e = exp_b.pop_front();
                bad = -1;
                for (int c = 0; c < CHB; c++)
                    if (b_odata[c*DW +: DW] !== e[c*DW +: DW] && bad < 0) bad = c;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL b_result ch%0d got %0d exp %0d", bad,
                             $signed(b_odata[bad*DW +: DW]), $signed(e[bad*DW +: DW]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic beat_a(input vec_a_t d, input logic m);
        int n;
        n = 0;
        @(negedge clk);
        a_data = d; a_valid = 1'b1; a_mode = m;
        while (!a_ready && n < 500) begin @(negedge clk); n++; end
        chk("a_accept_wait", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic beat_b(input vec_b_t d, input logic m, output int at);
        int n;
        n = 0;
        @(negedge clk);
        b_data = d; b_valid = 1'b1; b_mode = m;
        while (!b_ready && n < 500) begin @(negedge clk); n++; end
        chk("b_accept_wait", 64'(b_ready), 64'd1);
        @(posedge clk);
        at = cyc;
        #1 b_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin @(negedge clk); n++; end
        chk("scoreboard_drain", 64'(exp_a.size() + exp_b.size()), 64'd0);
    endtask

    initial begin : stim
        vec_a_t v, e;
        vec_b_t vb, eb;
        int t0, t1, t2, tx;
        int vals[4];
        vals = '{-1, -7, 3, -2};

        repeat (3) @(negedge clk);
        chk("reset_valid_out", 64'(a_vout), 64'd0);
        chk("reset_o_data", 64'(a_odata[DW-1:0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(a_ready), 64'd1);

        // 1: max with mixed signs
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(48 * c);
        e[0 +: DW] = DW'(24);
        e[DW +: DW] = DW'(-5);
        exp_a.push_back(e);
        for (int p = 0; p < 49; p++) begin
            for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(p * c);
            v[0 +: DW] = DW'(p - 24);
            v[DW +: DW] = DW'(-5);
            beat_a(v, 1'b0);
        end
        @(negedge clk);
        chk("t1_final_cycle_valid", 64'(a_vout), 64'd0);
        @(negedge clk);
        chk("t1_latency_valid", 64'(a_vout), 64'd1);
        drain();

        // 2: average, including rounding of 49
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(1000);
        e[0 +: DW] = DW'(49);
        exp_a.push_back(e);
        v = e;
        for (int p = 0; p < 49; p++) beat_a(v, 1'b1);
        drain();

        // 3: backpressure; next frame's first beat waits during HOLD
        a_oready = 1'b0;
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(48 + c);
        exp_a.push_back(e);
        for (int p = 0; p < 49; p++) begin
            for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(p + c);
            beat_a(v, 1'b0);
        end
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(500 + c);
        exp_a.push_back(e);
        fork
            begin
                int n;
                n = 0;
                while (!a_vout && n < 20) begin @(negedge clk); n++; end
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("t3_hold_valid", 64'(a_vout), 64'd1);
                    chk("t3_hold_in_ready", 64'(a_ready), 64'd0);
                    chk("t3_hold_ch5", 64'(a_odata[5*DW +: DW]), 64'd53);
                end
                @(posedge clk);
                #1 a_oready = 1'b1;
            end
            begin
                for (int p = 0; p < 49; p++) begin
                    for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'((p == 0) ? 500 + c : c);
                    beat_a(v, 1'b0);
                end
            end
        join
        drain();

        // 4: random gaps, mode flips mid max frame, next frame averages
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(100 + c);
        exp_a.push_back(e);
        for (int p = 0; p < 49; p++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'((p == 30) ? 100 + c : c - p);
            beat_a(v, p >= 10);
        end
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(2 * c);
        exp_a.push_back(e);
        v = e;
        for (int p = 0; p < 49; p++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            beat_a(v, 1'b1);
        end
        drain();

        // 5: reset mid-frame discards the partial frame
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(7);
        for (int p = 0; p < 20; p++) beat_a(v, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_reset_valid_out", 64'(a_vout), 64'd0);
        chk("t5_reset_o_data_ch31", 64'(a_odata[31*DW +: DW]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < CH; c++) e[c*DW +: DW] = DW'(1);
        exp_a.push_back(e);
        v = e;
        for (int p = 0; p < 49; p++) beat_a(v, 1'b1);
        drain();

        // 6: WIDTH=2 extremes and back-to-back frame period of DIM+2
        for (int c = 0; c < CHB; c++) eb[c*DW +: DW] = 32'h7fff_ffff;
        exp_b.push_back(eb);
        vb = eb;
        for (int p = 0; p < 4; p++) begin
            beat_b(vb, 1'b1, tx);
            if (p == 0) t0 = tx;
        end
        for (int c = 0; c < CHB; c++) eb[c*DW +: DW] = 32'h8000_0000;
        exp_b.push_back(eb);
        vb = eb;
        for (int p = 0; p < 4; p++) begin
            beat_b(vb, 1'b1, tx);
            if (p == 0) t1 = tx;
        end
        for (int c = 0; c < CHB; c++) eb[c*DW +: DW] = DW'(3 + c);
        exp_b.push_back(eb);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < CHB; c++) vb[c*DW +: DW] = DW'(vals[p] + c);
            beat_b(vb, 1'b0, tx);
            if (p == 0) t2 = tx;
        end
        chk("t6_period_0_1", 64'(t1 - t0), 64'd6);
        chk("t6_period_1_2", 64'(t2 - t1), 64'd6);
        drain();

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
